// File: rtl/vend_pkg.sv
// Shared types and constants for the vending purchase controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

endpackage

// File: rtl/coin_decode.sv
// Maps a coin strobe and coin code to a credit value plus an invalid-coin flag.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the value is credited.
module coin_decode
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic [CREDIT_W-1:0] value,
  output logic                invalid
);

  // Decode the coin code; value is zero whenever no creditable coin is present.
  always_comb begin
    value   = '0;
    invalid = 1'b0;
    if (coin_valid) begin
      case (coin_type)
        COIN_NICKEL:  value = CREDIT_W'(VAL_NICKEL);
        COIN_DIME:    value = CREDIT_W'(VAL_DIME);
        COIN_QUARTER: value = CREDIT_W'(VAL_QUARTER);
        default:      invalid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Purchase FSM: accumulates coin credit, pulses dispense at price, returns change/refund.
// Latency: outputs registered; dispense one cycle after the threshold coin, change from the next.
// Backpressure: coins arriving in VEND/CHANGE are rejected (coin_reject), cancel ignored there.
// Optional feature macro: VEND_CHANGE_EN (change/refund path; undefined keeps remainder as credit).
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_nickel,
  output logic                change_dime,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] TEN_C   = CREDIT_W'(VAL_DIME);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(VAL_NICKEL);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                dispense_d, nickel_d, dime_d, reject_d, busy_d;

  logic [CREDIT_W-1:0] coin_value;
  logic                coin_invalid;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] remainder;

  coin_decode #(
    .CREDIT_W (CREDIT_W)
  ) u_coin_decode (
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .value      (coin_value),
    .invalid    (coin_invalid)
  );

  // Credit never exceeds PRICE+20, so neither sum nor remainder can wrap.
  assign sum       = credit + coin_value;
  assign remainder = credit - PRICE_C;

`ifndef VEND_CHANGE_EN
  // Refunds do not exist in this build, so cancel has no consumer.
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  // Next-state, next-credit and next-output decisions for the purchase sequence.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit;
    dispense_d = 1'b0;
    nickel_d   = 1'b0;
    dime_d     = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      COLLECT: begin
`ifdef VEND_CHANGE_EN
        if (cancel && (credit != '0)) begin
          // Refund wins over a coin in the same cycle; that coin is bounced.
          state_d  = CHANGE;
          reject_d = coin_valid;
        end else
`endif
        if (coin_invalid) begin
          reject_d = 1'b1;
        end else if (coin_valid) begin
          credit_d = sum;
          if (sum >= PRICE_C) state_d = VEND;
        end
      end
      VEND: begin
        dispense_d = 1'b1;
        reject_d   = coin_valid;
        credit_d   = remainder;
`ifdef VEND_CHANGE_EN
        state_d    = (remainder != '0) ? CHANGE : COLLECT;
`else
        state_d    = (remainder >= PRICE_C) ? VEND : COLLECT;
`endif
      end
`ifdef VEND_CHANGE_EN
      CHANGE: begin
        reject_d = coin_valid;
        if (credit >= TEN_C) begin
          dime_d   = 1'b1;
          credit_d = credit - TEN_C;
        end else if (credit == FIVE_C) begin
          nickel_d = 1'b1;
          credit_d = credit - FIVE_C;
        end
        if (credit_d == '0) state_d = COLLECT;
      end
`endif
      default: state_d = COLLECT;
    endcase
    busy_d = (state_d != COLLECT);
  end

  // State, credit and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      credit        <= '0;
      dispense      <= 1'b0;
      change_nickel <= 1'b0;
      change_dime   <= 1'b0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit        <= credit_d;
      dispense      <= dispense_d;
      change_nickel <= nickel_d;
      change_dime   <= dime_d;
      coin_reject   <= reject_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller with PRICE=15.
// Model plans each purchase as a schedule of future pulses; compared every negedge.
// Directed scenarios add hand-computed literal checks; works with or without VEND_CHANGE_EN.
module tb_vend_controller;

  localparam int PRICE    = 15;
  localparam int CREDIT_W = 7;
`ifdef VEND_CHANGE_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                coin_valid = 1'b0;
  logic [1:0]          coin_type = 2'b00;
  logic                cancel = 1'b0;
  logic                dispense, change_nickel, change_dime, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;

  vend_controller #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .cancel        (cancel),
    .dispense      (dispense),
    .change_nickel (change_nickel),
    .change_dime   (change_dime),
    .coin_reject   (coin_reject),
    .busy          (busy),
    .credit        (credit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit d;
    bit n;
    bit m;
    int cr;
  } ev_t;

  ev_t sched[$];
  int  m_credit = 0;
  bit  e_disp = 0, e_nick = 0, e_dime = 0, e_rej = 0, e_busy = 0;

  function automatic int coin_val(input logic [1:0] ct);
    case (ct)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  function automatic void plan_refund(input int amount);
    int c = amount;
    ev_t e;
    while (c >= 10) begin
      c -= 10;
      e = '{d: 1'b0, n: 1'b0, m: 1'b1, cr: c};
      sched.push_back(e);
    end
    if (c == 5) begin
      e = '{d: 1'b0, n: 1'b1, m: 1'b0, cr: 0};
      sched.push_back(e);
    end
  endfunction

  function automatic void plan_vend(input int amount);
    int c = amount;
    ev_t e;
    do begin
      c -= PRICE;
      e = '{d: 1'b1, n: 1'b0, m: 1'b0, cr: c};
      sched.push_back(e);
    end while (!CHG && c >= PRICE);
    if (CHG) plan_refund(c);
  endfunction

  function automatic void model_edge(input bit cv, input logic [1:0] ct, input bit cn);
    ev_t e;
    e_disp = 0; e_nick = 0; e_dime = 0; e_rej = 0;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      e_disp = e.d; e_nick = e.n; e_dime = e.m; m_credit = e.cr;
      e_rej = cv;
    end else if (CHG && cn && m_credit > 0) begin
      e_rej = cv;
      plan_refund(m_credit);
    end else if (cv) begin
      if (coin_val(ct) == 0) e_rej = 1;
      else begin
        m_credit += coin_val(ct);
        if (m_credit >= PRICE) plan_vend(m_credit);
      end
    end
    e_busy = (sched.size() > 0);
  endfunction

  function automatic void model_clear();
    sched.delete();
    m_credit = 0;
    e_disp = 0; e_nick = 0; e_dime = 0; e_rej = 0; e_busy = 0;
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int n_disp = 0, n_nick = 0, n_dime = 0;

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_credit", int'(credit), m_credit);
      chk("cyc_dispense", int'(dispense), int'(e_disp));
      chk("cyc_change_nickel", int'(change_nickel), int'(e_nick));
      chk("cyc_change_dime", int'(change_dime), int'(e_dime));
      chk("cyc_coin_reject", int'(coin_reject), int'(e_rej));
      chk("cyc_busy", int'(busy), int'(e_busy));
      n_disp += int'(dispense);
      n_nick += int'(change_nickel);
      n_dime += int'(change_dime);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit cv, input logic [1:0] ct, input bit cn);
    @(negedge clk);
    #1;
    coin_valid = cv; coin_type = ct; cancel = cn;
    @(posedge clk);
    model_edge(cv, ct, cn);
    #1;
    coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_disp = 0; n_nick = 0; n_dime = 0;
  endtask

  initial begin
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_busy", int'(busy), 0);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Dime then nickel: exact price.
    step(1'b1, 2'b10, 1'b0);
    chk("dn_credit10", int'(credit), 10);
    step(1'b1, 2'b01, 1'b0);
    chk("dn_credit15", int'(credit), 15);
    chk("dn_busy", int'(busy), 1);
    idle(1);
    chk("dn_dispense", int'(dispense), 1);
    chk("dn_credit0", int'(credit), 0);
    idle(2);
    chk("dn_ndisp", n_disp, 1);
    chk("dn_nchange", n_nick + n_dime, 0);

    // Quarter: 10 remains after vend.
    apply_reset();
    step(1'b1, 2'b11, 1'b0);
    chk("q_credit25", int'(credit), 25);
    idle(1);
    chk("q_dispense", int'(dispense), 1);
    chk("q_credit10", int'(credit), 10);
    idle(1);
`ifdef VEND_CHANGE_EN
    chk("q_dime", int'(change_dime), 1);
    chk("q_credit0", int'(credit), 0);
`else
    chk("q_keep10", int'(credit), 10);
    chk("q_idle", int'(busy), 0);
`endif
    idle(2);
    chk("q_ndisp", n_disp, 1);
    chk("q_ndime", n_dime, CHG ? 1 : 0);

    // Two dimes: 5 remains after vend.
    apply_reset();
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk("dd_credit20", int'(credit), 20);
    idle(1);
    chk("dd_dispense", int'(dispense), 1);
    chk("dd_credit5", int'(credit), 5);
    idle(1);
`ifdef VEND_CHANGE_EN
    chk("dd_nickel", int'(change_nickel), 1);
    chk("dd_credit0", int'(credit), 0);
`else
    chk("dd_nonickel", int'(change_nickel), 0);
    chk("dd_keep5", int'(credit), 5);
`endif
    idle(2);

    // Nickel then cancel.
    apply_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    idle(1);
`ifdef VEND_CHANGE_EN
    chk("nc_nickel", int'(change_nickel), 1);
    chk("nc_credit0", int'(credit), 0);
`else
    chk("nc_keep5", int'(credit), 5);
`endif
    idle(2);
    chk("nc_ndisp", n_disp, 0);

    // Cancel and dime in the same cycle with 5 credited.
    apply_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b1);
`ifdef VEND_CHANGE_EN
    chk("cd_reject", int'(coin_reject), 1);
    chk("cd_credit5", int'(credit), 5);
    idle(3);
    chk("cd_nnick", n_nick, 1);
    chk("cd_ndime", n_dime, 0);
`else
    chk("cd_noreject", int'(coin_reject), 0);
    chk("cd_credit15", int'(credit), 15);
    idle(3);
    chk("cd_ndisp", n_disp, 1);
`endif

    // Invalid coin in COLLECT, then dimes during VEND and CHANGE.
    apply_reset();
    step(1'b1, 2'b00, 1'b0);
    chk("inv_reject", int'(coin_reject), 1);
    chk("inv_credit", int'(credit), 0);
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk("bv_dispense", int'(dispense), 1);
    chk("bv_reject", int'(coin_reject), 1);
    chk("bv_credit10", int'(credit), 10);
    step(1'b1, 2'b10, 1'b0);
`ifdef VEND_CHANGE_EN
    chk("bc_dime", int'(change_dime), 1);
    chk("bc_reject", int'(coin_reject), 1);
    chk("bc_credit0", int'(credit), 0);
`else
    chk("bc_noreject", int'(coin_reject), 0);
    chk("bc_credit20", int'(credit), 20);
`endif
    idle(4);

    // Asynchronous reset mid-sequence, then a fresh dime.
    apply_reset();
    step(1'b1, 2'b11, 1'b0);
    idle(1);
    chk("ar_dispense_before", int'(dispense), 1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("ar_dispense", int'(dispense), 0);
    chk("ar_credit", int'(credit), 0);
    chk("ar_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 2'b10, 1'b0);
    chk("ar_credit10", int'(credit), 10);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
